// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter: source indices, FSM states and
// the fixed-priority encoder (bit 0 = score is the highest priority).
package buzzer_pkg;

  localparam int CNT_W_DEF = 20;

  typedef logic [1:0] src_t;

  localparam src_t SRC_SCORE  = 2'd0;
  localparam src_t SRC_PADDLE = 2'd1;
  localparam src_t SRC_WALL   = 2'd2;
  localparam src_t SRC_MENU   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic src_t prio_enc(input logic [3:0] pend);
    src_t s;
    s = SRC_MENU;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) s = src_t'(i);
    end
    return s;
  endfunction

  // Pending bits that outrank source s.
  function automatic logic [3:0] higher_mask(input src_t s);
    return (4'b0001 << s) - 4'b0001;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// Loadable half-period divider: square wave restarts high on load, toggles
// every half_period enabled cycles, and is forced low by clr.
module tone_gen
  import buzzer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half_period,
  output logic             wave
);

  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hp_q <= '0;
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (load) begin
      hp_q <= half_period;
      cnt  <= half_period;
      wave <= 1'b1;
    end else if (en) begin
      if (cnt <= CNT_W'(1)) begin
        cnt  <= hp_q;
        wave <= ~wave;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter: latched request pulses, per-source tone, silent gap.
// Request-to-tone latency 2 edges; BUZZER_PREEMPT_EN lets higher priority abort a tone.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned HP_SCORE   = 3000,
  parameter int unsigned HP_PADDLE  = 6000,
  parameter int unsigned HP_WALL    = 12000,
  parameter int unsigned HP_MENU    = 1500,
  parameter int unsigned DUR_SCORE  = 600000,
  parameter int unsigned DUR_PADDLE = 120000,
  parameter int unsigned DUR_WALL   = 120000,
  parameter int unsigned DUR_MENU   = 60000,
  parameter int unsigned GAP_CYCLES = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_score,
  input  logic       req_paddle,
  input  logic       req_wall,
  input  logic       req_menu,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src
);

  // Zero-length settings would never terminate a down-count; clamp to 1.
  function automatic logic [CNT_W-1:0] sat1(input int unsigned v);
    logic [CNT_W-1:0] r;
    r = CNT_W'(v);
    return (r == '0) ? CNT_W'(1) : r;
  endfunction

  localparam logic [CNT_W-1:0] HP_S  = sat1(HP_SCORE);
  localparam logic [CNT_W-1:0] HP_P  = sat1(HP_PADDLE);
  localparam logic [CNT_W-1:0] HP_W  = sat1(HP_WALL);
  localparam logic [CNT_W-1:0] HP_M  = sat1(HP_MENU);
  localparam logic [CNT_W-1:0] DUR_S = sat1(DUR_SCORE);
  localparam logic [CNT_W-1:0] DUR_P = sat1(DUR_PADDLE);
  localparam logic [CNT_W-1:0] DUR_W = sat1(DUR_WALL);
  localparam logic [CNT_W-1:0] DUR_M = sat1(DUR_MENU);
  localparam logic [CNT_W-1:0] GAP_V = sat1(GAP_CYCLES);

  state_t           state;
  logic [3:0]       pending;
  logic [3:0]       pending_nxt;
  logic [3:0]       req_vec;
  logic [3:0]       set_bits;
  logic [3:0]       clr_bits;
  logic [3:0]       drop_bits;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dur_sel;
  logic [CNT_W-1:0] hp_sel;
  src_t             grant_src;
  logic             start;
  logic             play_end;

  assign req_vec   = {req_menu, req_wall, req_paddle, req_score};
  assign grant_src = prio_enc(pending);

  always_comb begin
    start = 1'b0;
    case (state)
      IDLE: start = |pending;
`ifdef BUZZER_PREEMPT_EN
      PLAY: start = |(pending & higher_mask(src_t'(active_src)));
`endif
      default: start = 1'b0;
    endcase
    if (mute) start = 1'b0;

    play_end    = !mute && !start && (state == PLAY) && (cnt <= CNT_W'(1));
    drop_bits   = (state == PLAY) ? (4'b0001 << active_src) : 4'b0000;
    set_bits    = mute ? 4'b0000 : (req_vec & ~drop_bits);
    clr_bits    = start ? (4'b0001 << grant_src) : 4'b0000;
    pending_nxt = mute ? 4'b0000 : ((pending & ~clr_bits) | set_bits);

    case (grant_src)
      SRC_SCORE:  begin hp_sel = HP_S; dur_sel = DUR_S; end
      SRC_PADDLE: begin hp_sel = HP_P; dur_sel = DUR_P; end
      SRC_WALL:   begin hp_sel = HP_W; dur_sel = DUR_W; end
      default:    begin hp_sel = HP_M; dur_sel = DUR_M; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= 4'b0000;
      cnt        <= '0;
      busy       <= 1'b0;
      active_src <= SRC_SCORE;
    end else begin
      pending <= pending_nxt;
      if (mute) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else if (start) begin
        state      <= PLAY;
        busy       <= 1'b1;
        active_src <= grant_src;
        cnt        <= dur_sel;
      end else begin
        case (state)
          PLAY: begin
            if (cnt <= CNT_W'(1)) begin
              state <= GAP;
              cnt   <= GAP_V;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt <= CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .en         (state == PLAY),
    .clr        (mute | play_end),
    .half_period(hp_sel),
    .wave       (buzzer)
  );

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter with short tones (HP=4, DUR=40, GAP=8); tone starts are
// scoreboarded against an expected {source, edge} queue.
module tb_buzzer_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_score = 1'b0;
  logic       req_paddle = 1'b0;
  logic       req_wall = 1'b0;
  logic       req_menu = 1'b0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_src;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] src;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  logic       prev_busy = 1'b0;
  logic [1:0] prev_src  = 2'd0;

  buzzer_arbiter #(
    .CNT_W(20),
    .HP_SCORE(4), .HP_PADDLE(4), .HP_WALL(4), .HP_MENU(4),
    .DUR_SCORE(40), .DUR_PADDLE(40), .DUR_WALL(40), .DUR_MENU(40),
    .GAP_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_score (req_score),
    .req_paddle(req_paddle),
    .req_wall  (req_wall),
    .req_menu  (req_menu),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .active_src(active_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // A tone start is busy rising or the playing source changing while busy.
  always @(negedge clk) begin
    exp_t e;
    if (busy && (!prev_busy || active_src != prev_src)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tone_start unexpected: src=%0d edge=%0d, none required", active_src, cyc);
      end else begin
        e = exp_q.pop_front();
        if (active_src !== e.src || cyc !== e.cyc) begin
          bad++;
          $display("FAIL tone_start: got src=%0d edge=%0d, required src=%0d edge=%0d",
                   active_src, cyc, e.src, e.cyc);
        end
      end
    end
    prev_busy = busy;
    prev_src  = active_src;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (active_src !== 2'd0) begin bad++; $display("FAIL reset_src: got %0d want 0", active_src); end
    reset = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single();
    int g;
    logic exp_b;
    req_paddle = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd1, cyc: g});
    step();
    req_paddle = 1'b0;
    step();
    for (int j = 0; j < 56; j++) begin
      exp_b = (j < 40) && (((j / 4) % 2) == 0);
      total++;
      if (buzzer !== exp_b) begin
        bad++;
        $display("FAIL single_wave j=%0d: got %b want %b", j, buzzer, exp_b);
      end
      if (j != 48) begin
        total++;
        if (busy !== (j < 48)) begin
          bad++;
          $display("FAIL single_busy j=%0d: got %b want %b", j, busy, (j < 48));
        end
      end
      if (j == 0 || j == 55) begin
        total++;
        if (active_src !== 2'd1) begin
          bad++;
          $display("FAIL single_src j=%0d: got %0d want 1", j, active_src);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int g;
    req_paddle = 1'b1;
    req_wall   = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd1, cyc: g});
    exp_q.push_back('{src: 2'd2, cyc: g + 49});
    step();
    req_paddle = 1'b0;
    req_wall   = 1'b0;
    while (cyc < g + 40) step();
    for (int j = 40; j <= 48; j++) begin
      total++;
      if (buzzer !== 1'b0) begin bad++; $display("FAIL b2b_silent j=%0d: got %b want 0", j, buzzer); end
      step();
    end
    total++;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL b2b_second_high: got %b want 1", buzzer); end
    total++;
    if (active_src !== 2'd2) begin bad++; $display("FAIL b2b_second_src: got %0d want 2", active_src); end
    while (cyc < g + 49 + 52) step();
  endtask

  task automatic test_queue();
    int g;
    req_wall = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd2, cyc: g});
`ifdef BUZZER_PREEMPT_EN
    exp_q.push_back('{src: 2'd0, cyc: g + 11});
    exp_q.push_back('{src: 2'd3, cyc: g + 60});
`else
    exp_q.push_back('{src: 2'd0, cyc: g + 49});
    exp_q.push_back('{src: 2'd3, cyc: g + 98});
`endif
    step();
    req_wall = 1'b0;
    while (cyc < g + 2) step();
    req_wall = 1'b1;          // same source as playing: dropped
    step();
    req_wall = 1'b0;
    while (cyc < g + 4) step();
    req_menu = 1'b1;
    step();
    req_menu = 1'b0;
    step();
    req_menu = 1'b1;          // coalesces with the pending menu bit
    step();
    req_menu = 1'b0;
    while (cyc < g + 9) step();
    req_score = 1'b1;
    step();
    req_score = 1'b0;
    step();
`ifdef BUZZER_PREEMPT_EN
    total++;
    if (buzzer !== 1'b1 || active_src !== 2'd0) begin
      bad++;
      $display("FAIL preempt_start: got buzzer=%b src=%0d want 1/0", buzzer, active_src);
    end
`else
    total++;
    if (active_src !== 2'd2) begin bad++; $display("FAIL no_preempt_src: got %0d want 2", active_src); end
`endif
    while (cyc < g + 150) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL queue_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_mute();
    int g;
    req_paddle = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd1, cyc: g});
    step();
    req_paddle = 1'b0;
    while (cyc < g + 4) step();
    req_wall = 1'b1;
    step();
    req_wall = 1'b0;
    while (cyc < g + 9) step();
    mute = 1'b1;
    step();
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL mute_buzzer: got %b want 0", buzzer); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mute_busy: got %b want 0", busy); end
    req_score = 1'b1;         // ignored while muted
    step();
    req_score = 1'b0;
    while (cyc < g + 14) step();
    mute = 1'b0;
    while (cyc < g + 60) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mute_flush_busy: got %b want 0", busy); end
    while (cyc < g + 100) step();
    total++;
    if (buzzer !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mute_after: got buzzer=%b busy=%b want 0/0", buzzer, busy);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    req_paddle = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd1, cyc: g});
    step();
    req_paddle = 1'b0;
    while (cyc < g + 10) step();
    #2 reset = 1'b0;
    #1;
    total++;
    if (buzzer !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got buzzer=%b busy=%b want 0/0", buzzer, busy);
    end
    total++;
    if (active_src !== 2'd0) begin bad++; $display("FAIL async_reset_src: got %0d want 0", active_src); end
    step();
    reset = 1'b1;
    repeat (60) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_resume: got busy=%b want 0", busy); end
    req_score = 1'b1;
    g = cyc + 2;
    exp_q.push_back('{src: 2'd0, cyc: g});
    step();
    req_score = 1'b0;
    step();
    total++;
    if (buzzer !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_start: got buzzer=%b busy=%b want 1/1", buzzer, busy);
    end
    while (cyc < g + 40) step();
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL post_reset_end: got %b want 0", buzzer); end
    while (cyc < g + 52) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_queue();
    test_mute();
    test_reset_mid();
    repeat (5) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL tone_start missing: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
